// File: rtl/vga_sync_gen.sv
// VGA display timing generator, clocked by clk_100mhz and advanced one pixel per pix_en strobe.
//
// Ports:
//   clk_100mhz   in   system clock
//   rst          in   asynchronous, active-high reset
//   pix_en       in   pixel strobe, one clk_100mhz cycle high per pixel
//   hsync        out  horizontal sync, asserted level = SYNC_POL
//   vsync        out  vertical sync, asserted level = SYNC_POL
//   video_on     out  high while (x,y) lies in the visible area
//   x            out  horizontal pixel counter, 0..H_TOTAL-1
//   y            out  line counter, 0..V_TOTAL-1
//   frame_start  out  one-cycle pulse when the counters enter (0,0)
//   line_start   out  one-cycle pulse when x enters 0
//
// Every output is registered from the next-state counters, so the decoded
// flags always match the x/y they are presented with.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       line_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // 11-bit bounds: a sync window ending exactly at 1024 must still be representable.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_cfg
    $error("vga_sync_gen: line/frame totals must be in 1..1024");
  end

  logic [9:0] x_d;
  logic [9:0] y_d;
  logic       x_wrap;
  logic       hsync_d;
  logic       vsync_d;
  logic       video_on_d;
  logic       line_start_d;
  logic       frame_start_d;

  // Counter progression: x wraps at H_TOTAL, y steps only on that wrap.
  always_comb begin
    x_wrap = (x == H_LAST);
    x_d    = x_wrap ? 10'd0 : x + 10'd1;
    y_d    = y;
    if (x_wrap) begin
      y_d = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end
  end

  // Decode from the next-state counters so outputs align with the new x/y.
  always_comb begin
    hsync_d = ~SYNC_POL;
    vsync_d = ~SYNC_POL;
    if ({1'b0, x_d} >= H_SYNC_BEG && {1'b0, x_d} < H_SYNC_END) begin
      hsync_d = SYNC_POL;
    end
    if ({1'b0, y_d} >= V_SYNC_BEG && {1'b0, y_d} < V_SYNC_END) begin
      vsync_d = SYNC_POL;
    end
    video_on_d    = ({1'b0, x_d} < H_VIS_END) && ({1'b0, y_d} < V_VIS_END);
    line_start_d  = (x_d == 10'd0);
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
  end

  // Reset parks the counters on the last pixel so the first strobe lands on (0,0).
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      x           <= H_LAST;
      y           <= V_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Pulses last a single clk_100mhz cycle, even with pix_en held high.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        x           <= x_d;
        y           <= y_d;
        hsync       <= hsync_d;
        vsync       <= vsync_d;
        video_on    <= video_on_d;
        line_start  <= line_start_d;
        frame_start <= frame_start_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a default-timing instance and a tiny
// active-high-sync instance share clock, reset and strobe. A linear pixel-position
// model predicts both every cycle; a vector table and hand sequences cover corners.
module tb_vga_sync_gen;

  typedef struct {
    int hv, hfp, hs, hbp, vv, vfp, vs, vbp;
    bit pol;
  } cfg_t;

  typedef struct {
    bit         rst;
    bit         pix;
    logic [9:0] x;
    logic [9:0] y;
    bit         hs, vs, vo, fs, ls;
  } vec_t;

  cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  cfg_t cfg_b = '{8, 2, 3, 3, 6, 1, 2, 2, 1'b1};

  logic clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  logic       rst;
  logic       pix_en;
  logic       hs_a, vs_a, vo_a, fs_a, ls_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, vo_b, fs_b, ls_b;
  logic [9:0] x_b, y_b;

  int checks   = 0;
  int failures = 0;
  bit sb_en    = 1'b0;

  vga_sync_gen u_dut_a (
    .clk_100mhz  (clk_100mhz),
    .rst         (rst),
    .pix_en      (pix_en),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .video_on    (vo_a),
    .x           (x_a),
    .y           (y_a),
    .frame_start (fs_a),
    .line_start  (ls_a)
  );

  vga_sync_gen #(
    .H_VISIBLE (8),
    .H_FP      (2),
    .H_SYNC    (3),
    .H_BP      (3),
    .V_VISIBLE (6),
    .V_FP      (1),
    .V_SYNC    (2),
    .V_BP      (2),
    .SYNC_POL  (1'b1)
  ) u_dut_b (
    .clk_100mhz  (clk_100mhz),
    .rst         (rst),
    .pix_en      (pix_en),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .video_on    (vo_b),
    .x           (x_b),
    .y           (y_b),
    .frame_start (fs_b),
    .line_start  (ls_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int ht(cfg_t c);
    return c.hv + c.hfp + c.hs + c.hbp;
  endfunction

  function automatic int tot(cfg_t c);
    return ht(c) * (c.vv + c.vfp + c.vs + c.vbp);
  endfunction

  // Expected {x, y, hsync, vsync, video_on, frame_start, line_start} from a raster position.
  function automatic logic [24:0] model_out(cfg_t c, int pos, bit fs, bit ls);
    int px, py;
    bit h, v, vo;
    px = pos % ht(c);
    py = pos / ht(c);
    h  = (px >= c.hv + c.hfp && px < c.hv + c.hfp + c.hs) ? c.pol : ~c.pol;
    v  = (py >= c.vv + c.vfp && py < c.vv + c.vfp + c.vs) ? c.pol : ~c.pol;
    vo = (px < c.hv) && (py < c.vv);
    return {10'(px), 10'(py), h, v, vo, fs, ls};
  endfunction

  // Reference: a single position in the raster that advances by one per strobe.
  int pos_a, pos_b;
  bit mfs_a, mls_a, mfs_b, mls_b;

  always @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      pos_a <= tot(cfg_a) - 1;
      pos_b <= tot(cfg_b) - 1;
      mfs_a <= 1'b0;
      mls_a <= 1'b0;
      mfs_b <= 1'b0;
      mls_b <= 1'b0;
    end else begin
      mls_a <= pix_en && ((pos_a + 1) % ht(cfg_a) == 0);
      mfs_a <= pix_en && ((pos_a + 1) % tot(cfg_a) == 0);
      mls_b <= pix_en && ((pos_b + 1) % ht(cfg_b) == 0);
      mfs_b <= pix_en && ((pos_b + 1) % tot(cfg_b) == 0);
      if (pix_en) begin
        pos_a <= (pos_a + 1) % tot(cfg_a);
        pos_b <= (pos_b + 1) % tot(cfg_b);
      end
    end
  end

  always @(negedge clk_100mhz) begin
    if (sb_en) begin
      check("scoreboard_a", 32'({x_a, y_a, hs_a, vs_a, vo_a, fs_a, ls_a}),
            32'(model_out(cfg_a, pos_a, mfs_a, mls_a)));
      check("scoreboard_b", 32'({x_b, y_b, hs_b, vs_b, vo_b, fs_b, ls_b}),
            32'(model_out(cfg_b, pos_b, mfs_b, mls_b)));
    end
  end

  vec_t tbl[8];

  initial begin
    int hs_low, first_hs_x, ls_cnt, ls_first, ls_last, bad;
    int fs_cnt, t0, t1, vs_cnt, vo_cnt, hsb_cnt, lsb_cnt;
    bit found;

    rst    = 1'b1;
    pix_en = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 10'd2,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk_100mhz);
      rst    = tbl[i].rst;
      pix_en = tbl[i].pix;
      @(posedge clk_100mhz);
      #1;
      check($sformatf("vector_%0d", i), 32'({x_a, y_a, hs_a, vs_a, vo_a, fs_a, ls_a}),
            32'({tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].vo, tbl[i].fs, tbl[i].ls}));
    end
    sb_en = 1'b1;

    // One full line with a 1-in-4 strobe; the sample at c=1 still shows the row-7 line_start.
    hs_low = 0; first_hs_x = -1; ls_cnt = 0; ls_first = 0; ls_last = 0;
    for (int c = 1; c <= 3201; c++) begin
      @(negedge clk_100mhz);
      if (!hs_a) begin
        if (hs_low == 0) first_hs_x = int'(x_a);
        hs_low++;
      end
      if (ls_a) begin
        if (ls_cnt == 0) ls_first = c;
        ls_last = c;
        ls_cnt++;
      end
      pix_en = (c % 4 == 0) && (c <= 3200);
    end
    check("hsync_low_cycles", 32'(hs_low), 32'd384);
    check("hsync_first_x", 32'(first_hs_x), 32'd656);
    check("line_start_count", 32'(ls_cnt), 32'd2);
    check("line_start_period", 32'(ls_last - ls_first), 32'd3200);
    check("line_end_xy", 32'({x_a, y_a}), 32'({10'd0, 10'd1}));

    // Advance to x=300 and hold the strobe low.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_100mhz);
      pix_en = 1'b1;
    end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_100mhz);
      pix_en = 1'b0;
      if (x_a != 10'd300 || y_a != 10'd1 || !hs_a || !vs_a || !vo_a || fs_a || ls_a) bad++;
    end
    check("freeze_bad_cycles", 32'(bad), 32'd0);
    check("freeze_x", 32'(x_a), 32'd300);

    // Small instance, continuous strobe: one whole frame between frame_start pulses.
    @(negedge clk_100mhz);
    rst = 1'b1;
    @(negedge clk_100mhz);
    rst = 1'b0;
    fs_cnt = 0; t0 = 0; t1 = 0; vs_cnt = 0; vo_cnt = 0; hsb_cnt = 0; lsb_cnt = 0;
    for (int s = 0; s < 400; s++) begin
      @(negedge clk_100mhz);
      if (fs_b) begin
        fs_cnt++;
        if (fs_cnt == 1) t0 = s;
        if (fs_cnt == 2) t1 = s;
      end
      if (fs_cnt == 1) begin
        if (vs_b) vs_cnt++;
        if (vo_b) vo_cnt++;
        if (hs_b) hsb_cnt++;
        if (ls_b) lsb_cnt++;
      end
      pix_en = 1'b1;
    end
    check("b_frame_period", 32'(t1 - t0), 32'd176);
    check("b_vsync_cycles", 32'(vs_cnt), 32'd32);
    check("b_video_on_cycles", 32'(vo_cnt), 32'd48);
    check("b_hsync_cycles", 32'(hsb_cnt), 32'd33);
    check("b_line_starts", 32'(lsb_cnt), 32'd11);

    // Reset while both syncs of the small instance are asserted.
    found = 1'b0;
    for (int s = 0; s < 400; s++) begin
      @(negedge clk_100mhz);
      if (hs_b && vs_b) begin
        found = 1'b1;
        break;
      end
      pix_en = 1'b1;
    end
    check("b_found_both_syncs", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("b_async_reset", 32'({x_b, y_b, hs_b, vs_b, vo_b, fs_b, ls_b}),
          32'({10'd15, 10'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    check("a_async_reset", 32'({x_a, y_a, hs_a, vs_a, vo_a}),
          32'({10'd799, 10'd524, 1'b1, 1'b1, 1'b0}));
    @(negedge clk_100mhz);
    rst    = 1'b0;
    pix_en = 1'b1;
    @(posedge clk_100mhz);
    #1;
    check("b_first_after_reset", 32'({x_b, y_b, vo_b, fs_b, ls_b}),
          32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));

    // Random strobes with rare reset pulses, checked by the scoreboard.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_100mhz);
      rst    = ($urandom_range(0, 2999) == 0);
      pix_en = $urandom_range(0, 1) == 1;
    end
    @(negedge clk_100mhz);
    rst    = 1'b0;
    pix_en = 1'b0;
    @(negedge clk_100mhz);
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
